// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone definitions for the round-robin arbiter slice.
//   WB_ADR_W / WB_DAT_W / WB_SEL_W : Wishbone bus widths
//   TMO_CNT_W                      : width of the stalled-strobe counter
//   arb_state_t                    : arbiter FSM state encoding
//   idx_w()                        : index width needed to address n masters
package wb_pkg;

  localparam int WB_ADR_W  = 32;
  localparam int WB_DAT_W  = 32;
  localparam int WB_SEL_W  = 4;
  localparam int TMO_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N_MASTER Wishbone masters, the arbiter and one shared slave.
//   m_cyc_i/m_stb_i/m_we_i  : per-master cycle, strobe, write enable
//   m_adr_i/m_dat_i/m_sel_i : per-master address, write data, byte selects
//                             (master k occupies slice k of each vector)
//   m_ack_o/m_err_o         : per-master acknowledge / error
//   m_dat_o                 : read data broadcast to all masters
//   s_*_o                   : shared slave request
//   s_dat_i/s_ack_i/s_err_i : slave response
// Modport slave is the arbiter's view; modport master is the environment's view.
interface wb_rr_arbiter_if #(
  parameter int N_MASTER = 4
);
  import wb_pkg::*;

  logic [N_MASTER-1:0]          m_cyc_i;
  logic [N_MASTER-1:0]          m_stb_i;
  logic [N_MASTER-1:0]          m_we_i;
  logic [WB_ADR_W*N_MASTER-1:0] m_adr_i;
  logic [WB_DAT_W*N_MASTER-1:0] m_dat_i;
  logic [WB_SEL_W*N_MASTER-1:0] m_sel_i;
  logic [N_MASTER-1:0]          m_ack_o;
  logic [N_MASTER-1:0]          m_err_o;
  logic [WB_DAT_W-1:0]          m_dat_o;

  logic                         s_cyc_o;
  logic                         s_stb_o;
  logic                         s_we_o;
  logic [WB_ADR_W-1:0]          s_adr_o;
  logic [WB_DAT_W-1:0]          s_dat_o;
  logic [WB_SEL_W-1:0]          s_sel_o;
  logic [WB_DAT_W-1:0]          s_dat_i;
  logic                         s_ack_i;
  logic                         s_err_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_picker.sv
// Combinational round-robin selector.
//   req_i      : request vector (one bit per master)
//   last_i     : index of the most recently served master
//   pick_o     : one-hot winner, zero when no request
//   pick_idx_o : index of the winner (0 when no request)
// Search starts at the master after last_i and wraps, so last_i itself has
// the lowest priority.
module rr_picker
  import wb_pkg::*;
#(
  parameter  int N_MASTER = 4,
  localparam int IDX_W    = idx_w(N_MASTER)
) (
  input  logic [N_MASTER-1:0] req_i,
  input  logic [IDX_W-1:0]    last_i,
  output logic [N_MASTER-1:0] pick_o,
  output logic [IDX_W-1:0]    pick_idx_o
);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int off = 1; off <= N_MASTER; off++) begin
      cand = int'(last_i) + off;
      if (cand >= N_MASTER) cand = cand - N_MASTER;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found            = 1'b1;
        pick_o[cand_idx] = 1'b1;
        pick_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between N_MASTER masters.
//   clk_i : clock, all state on the rising edge
//   rst_i : asynchronous active-high reset
//   bus   : master-side and slave-side Wishbone signals (slave modport)
//   gnt_o : one-hot registered grant, zero while idle
// A granted master keeps the slave until it drops cyc; the arbiter then spends
// one IDLE cycle before the next grant. A stalled strobe held for TIMEOUT
// cycles earns the master a one-cycle forced error without losing the grant.
//
// state   | meaning
// ST_IDLE | no grant; arbitrate among masters with cyc set
// ST_BUSY | gnt_q owns the slave; request mirrored, response routed back
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int N_MASTER = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_rr_arbiter_if.slave      bus,
  output logic [N_MASTER-1:0] gnt_o
);

  localparam int                   IDX_W     = idx_w(N_MASTER);
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT - 1);

  arb_state_t           state;
  logic [N_MASTER-1:0]  gnt_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic [IDX_W-1:0]     last_gnt_q;
  logic [TMO_CNT_W-1:0] tmo_cnt_q;

  logic [N_MASTER-1:0]  pick;
  logic [IDX_W-1:0]     pick_idx;

  logic                 mx_cyc;
  logic                 mx_stb;
  logic                 mx_we;
  logic [WB_ADR_W-1:0]  mx_adr;
  logic [WB_DAT_W-1:0]  mx_dat;
  logic [WB_SEL_W-1:0]  mx_sel;

  logic                 stall;
  logic                 tmo_hit;
  logic                 err_any;

  rr_picker #(.N_MASTER(N_MASTER)) u_picker (
    .req_i      (bus.m_cyc_i),
    .last_i     (last_gnt_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx)
  );

  // Request mux; everything stays zero outside BUSY so reset drops the
  // slave cycle immediately through the async-cleared state.
  always_comb begin
    mx_cyc = 1'b0;
    mx_stb = 1'b0;
    mx_we  = 1'b0;
    mx_adr = '0;
    mx_dat = '0;
    mx_sel = '0;
    if (state == ST_BUSY) begin
      mx_cyc = bus.m_cyc_i[gnt_idx_q];
      mx_stb = bus.m_stb_i[gnt_idx_q];
      mx_we  = bus.m_we_i[gnt_idx_q];
      mx_adr = bus.m_adr_i[int'(gnt_idx_q)*WB_ADR_W +: WB_ADR_W];
      mx_dat = bus.m_dat_i[int'(gnt_idx_q)*WB_DAT_W +: WB_DAT_W];
      mx_sel = bus.m_sel_i[int'(gnt_idx_q)*WB_SEL_W +: WB_SEL_W];
    end
  end

  assign bus.s_cyc_o = mx_cyc;
  assign bus.s_stb_o = mx_stb;
  assign bus.s_we_o  = mx_we;
  assign bus.s_adr_o = mx_adr;
  assign bus.s_dat_o = mx_dat;
  assign bus.s_sel_o = mx_sel;

  // A slave response in the would-be timeout cycle is not a stall, so the
  // real response wins over the forced error.
  assign stall   = mx_stb && !bus.s_ack_i && !bus.s_err_i;
  assign tmo_hit = stall && (tmo_cnt_q == TMO_LIMIT);
  assign err_any = bus.s_err_i || tmo_hit;

  // gnt_q is zero outside BUSY, so it alone gates response routing. Ack is
  // suppressed whenever err is present to keep the pair mutually exclusive.
  assign bus.m_ack_o = gnt_q & {N_MASTER{bus.s_ack_i && !bus.s_err_i}};
  assign bus.m_err_o = gnt_q & {N_MASTER{err_any}};
  assign bus.m_dat_o = bus.s_dat_i;
  assign gnt_o       = gnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_gnt_q <= IDX_W'(N_MASTER - 1);
      tmo_cnt_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt_q <= '0;
          if (|bus.m_cyc_i) begin
            gnt_q     <= pick;
            gnt_idx_q <= pick_idx;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!mx_cyc) begin
            state      <= ST_IDLE;
            gnt_q      <= '0;
            last_gnt_q <= gnt_idx_q;
            tmo_cnt_q  <= '0;
          end else if (stall && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end else begin
            tmo_cnt_q <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  import wb_pkg::*;

  localparam int N = 4;
  localparam int T = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] gnt_o;

  wb_rr_arbiter_if #(.N_MASTER(N)) bus ();

  wb_rr_arbiter #(.N_MASTER(N), .TIMEOUT(T)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus),
    .gnt_o (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          mst;
    bit          is_err;
    logic [31:0] rdata;
    logic [31:0] adr;
    logic [31:0] wdat;
    bit          we;
    logic [3:0]  sel;
  } resp_t;

  int     total = 0;
  int     bad   = 0;
  resp_t  resp_q[$];
  int     gnt_q[$];
  int     last_m;
  logic [N-1:0] prev_gnt = '0;
  resp_t  mon_r;
  int     mon_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester after 'last', wrapping.
  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_resp(input int g, input bit is_err);
    resp_t r;
    r.mst    = g;
    r.is_err = is_err;
    r.rdata  = bus.s_dat_i;
    r.adr    = bus.m_adr_i[g*32 +: 32];
    r.wdat   = bus.m_dat_i[g*32 +: 32];
    r.we     = bus.m_we_i[g];
    r.sel    = bus.m_sel_i[g*4 +: 4];
    resp_q.push_back(r);
  endtask

  // One beat: optional idle-strobe gap, w stalled cycles, then a response.
  task automatic do_beat(input int g, input int gap, input int w, input bit use_err);
    int s;
    s = 0;
    repeat (gap) begin
      bus.m_stb_i[g] = 1'b0;
      tick();
    end
    bus.m_stb_i[g]         = 1'b1;
    bus.m_we_i[g]          = 1'($urandom_range(0, 1));
    bus.m_adr_i[g*32 +: 32] = $urandom;
    bus.m_dat_i[g*32 +: 32] = $urandom;
    bus.m_sel_i[g*4 +: 4]   = 4'($urandom_range(0, 15));
    for (int i = 0; i <= w; i++) begin
      bus.s_dat_i = $urandom;
      if (i < w) begin
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        s++;
        if (s == T) begin
          push_resp(g, 1'b1);
          s = 0;
        end
      end else begin
        bus.s_ack_i = !use_err;
        bus.s_err_i = use_err;
        push_resp(g, use_err);
      end
      tick();
    end
    bus.s_ack_i    = 1'b0;
    bus.s_err_i    = 1'b0;
    bus.m_stb_i[g] = 1'b0;
  endtask

  // All masters in 'mask' raise cyc together and are served in RR order.
  task automatic run_round(input logic [N-1:0] mask, input int nbeats, input int wfix,
                           input bit allow_err);
    logic [N-1:0] pend;
    int g, nb, w;
    bit e;
    pend = mask;
    bus.m_cyc_i = mask;
    g = rr_next(pend, last_m);
    gnt_q.push_back(g);
    tick();
    while (pend != '0) begin
      nb = (nbeats > 0) ? nbeats : int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        w = (wfix >= 0) ? wfix : int'($urandom_range(0, 9));
        e = allow_err && ($urandom_range(0, 4) == 0);
        do_beat(g, (b == 0) ? 0 : int'($urandom_range(0, 1)), w, e);
      end
      bus.m_cyc_i[g] = 1'b0;
      pend[g] = 1'b0;
      last_m = g;
      #1;
      chk("s_cyc_drop", 32'(bus.s_cyc_o), 32'd0);
      if (pend != '0) begin
        g = rr_next(pend, last_m);
        gnt_q.push_back(g);
      end
      tick();
      chk("dead_gnt", 32'(gnt_o), 32'd0);
      if (pend != '0) tick();
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or a response.
  always @(negedge clk_i) begin
    if (gnt_o !== prev_gnt && gnt_o !== '0) begin
      chk("gnt_gap", 32'(prev_gnt), 32'd0);
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt_o), 32'd0);
      end else begin
        mon_g = gnt_q.pop_front();
        chk("gnt", 32'(gnt_o), 32'(1 << mon_g));
      end
    end
    if ((|bus.m_ack_o) || (|bus.m_err_o)) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", 32'({bus.m_ack_o, bus.m_err_o}), 32'd0);
      end else begin
        mon_r = resp_q.pop_front();
        chk("ack_vec", 32'(bus.m_ack_o), mon_r.is_err ? 32'd0 : 32'(1 << mon_r.mst));
        chk("err_vec", 32'(bus.m_err_o), mon_r.is_err ? 32'(1 << mon_r.mst) : 32'd0);
        chk("m_dat", bus.m_dat_o, mon_r.rdata);
        chk("s_adr", bus.s_adr_o, mon_r.adr);
        chk("s_dat", bus.s_dat_o, mon_r.wdat);
        chk("s_we", 32'(bus.s_we_o), 32'(mon_r.we));
        chk("s_sel", 32'(bus.s_sel_o), 32'(mon_r.sel));
        chk("s_cyc", 32'(bus.s_cyc_o), 32'd1);
      end
    end
    prev_gnt <= gnt_o;
  end

  initial begin
    int g;
    bus.m_cyc_i = '1;
    bus.m_stb_i = '1;
    bus.m_we_i  = '1;
    bus.m_adr_i = {N{32'hdead_beef}};
    bus.m_dat_i = {N{32'h1234_5678}};
    bus.m_sel_i = '1;
    bus.s_dat_i = 32'h0;
    bus.s_ack_i = 1'b1;
    bus.s_err_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(bus.s_stb_o), 32'd0);
    chk("rst_s_adr", bus.s_adr_o, 32'd0);
    chk("rst_s_dat", bus.s_dat_o, 32'd0);
    chk("rst_ack", 32'(bus.m_ack_o), 32'd0);
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.s_ack_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    last_m = N - 1;

    run_round(4'b1111, 1, 0, 1'b0);
    run_round(4'b0001, 1, 0, 1'b0);
    run_round(4'b0100, 3, -1, 1'b0);
    run_round(4'b1000, 1, 9, 1'b0);
    run_round(4'b0010, 1, 3, 1'b0);
    run_round(4'b1000, 2, 1, 1'b0);
    run_round(4'b1000, 1, 0, 1'b0);

    // Reset in the middle of a stalled BUSY transaction.
    bus.m_cyc_i = 4'b0110;
    g = rr_next(4'b0110, last_m);
    gnt_q.push_back(g);
    tick();
    bus.m_stb_i[g] = 1'b1;
    tick();
    tick();
    #2;
    rst_i = 1'b1;
    bus.s_ack_i = 1'b1;
    #1;
    chk("arst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("arst_s_stb", 32'(bus.s_stb_o), 32'd0);
    chk("arst_gnt", 32'(gnt_o), 32'd0);
    chk("arst_ack", 32'(bus.m_ack_o), 32'd0);
    chk("arst_err", 32'(bus.m_err_o), 32'd0);
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    last_m = N - 1;
    tick();
    run_round(4'b1111, 1, 0, 1'b0);

    repeat (40) run_round(4'($urandom_range(1, (1 << N) - 1)), 0, -1, 1'b1);

    repeat (3) tick();
    chk("resp_q_left", 32'(resp_q.size()), 32'd0);
    chk("gnt_q_left", 32'(gnt_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 4, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, max stb cycles without ack/err before a forced error (1..65535).
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m_cyc_i, m_stb_i, m_we_i  input  N_MASTER  per-master Wishbone cycle, strobe and write-enable.
REQ-006 SHALL have ports m_adr_i, m_dat_i  input  32*N_MASTER  per-master address and write data, master k in bits [32k+31:32k].
REQ-007 SHALL have port m_sel_i  input  4*N_MASTER  per-master byte selects.
REQ-008 SHALL have ports m_ack_o, m_err_o  output  N_MASTER  per-master acknowledge and error.
REQ-009 SHALL have port m_dat_o  output  32  read data broadcast to all masters.
REQ-010 SHALL have ports s_cyc_o, s_stb_o, s_we_o  output  1, s_adr_o, s_dat_o  output  32, s_sel_o  output  4  shared slave request.
REQ-011 SHALL have ports s_dat_i  input  32, s_ack_i, s_err_i  input  1  slave response.
REQ-012 SHALL have port gnt_o  output  N_MASTER  one-hot current grant, zero when idle.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-014 In IDLE with any m_cyc_i set, SHALL register a grant to the first requester after last_gnt in round-robin order (wrapping N_MASTER-1 -> 0) and enter BUSY; grant visible on gnt_o next cycle (latency 1).
REQ-015 In IDLE with no m_cyc_i set, SHALL stay in IDLE with gnt_o = 0.
REQ-016 In BUSY, s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o SHALL combinationally mirror the granted master; all zero in IDLE.
REQ-017 s_ack_i/s_err_i SHALL route combinationally only to the granted master; non-granted masters always see ack = err = 0.
REQ-018 m_dat_o SHALL equal s_dat_i at all times.
REQ-019 Grant SHALL be held while granted m_cyc_i stays high (multi-beat cycles and idle stb gaps allowed); other requests are ignored meanwhile.
REQ-020 When granted m_cyc_i is low in BUSY, SHALL return to IDLE next cycle, update last_gnt to that master, and drive s_cyc_o low that same cycle; arbitration resumes in IDLE (one dead cycle between grants).
REQ-021 SHALL count, in a 16-bit counter, consecutive BUSY cycles with s_stb_o high and s_ack_i = s_err_i = 0; counter clears on ack, err, stb low, or leaving BUSY.
REQ-022 When the counter reaches TIMEOUT, SHALL assert m_err_o of the granted master for exactly one cycle and clear the counter; grant is not revoked.
REQ-023 If s_ack_i or s_err_i arrives in the timeout cycle, slave response SHALL win and no forced error is issued.
REQ-024 m_err_o SHALL be the OR of routed s_err_i and forced timeout error; m_ack_o and m_err_o never both high for one master.

Reset
REQ-025 While rst_i high: state = IDLE, gnt_o = 0, counter = 0, last_gnt = N_MASTER-1 (master 0 wins first arbitration), all slave-side outputs 0.
REQ-026 Assertion mid-transaction SHALL drop s_cyc_o and all grants asynchronously, with no ack/err to any master.

Structure
REQ-027 Wishbone width constants (address 32, data 32, sel 4) and the FSM state enum SHALL live in shared package wb_pkg.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_picker (req vector, last_gnt in, one-hot pick out).
REQ-029 Total RTL SHALL be 120-400 lines; no latches, single clock domain.

Verification
REQ-030 After reset, m_cyc_i = 4'b1111 -> gnt_o = 4'b0001 one cycle later; each release yields grants 0010, 0100, 1000, 0001 in order.
REQ-031 Master 2 holds cyc for 3 beats with slave acking each -> 3 m_ack_o[2] pulses, m_ack_o[0,1,3] never set, gnt_o stable at 4'b0100.
REQ-032 TIMEOUT = 4, slave never acks -> m_err_o[granted] high exactly on 4th stb cycle, then again every 4 cycles until cyc drops.
REQ-033 TIMEOUT = 4, s_ack_i on 4th stb cycle -> m_ack_o pulse, no m_err_o.
REQ-034 rst_i asserted mid-BUSY -> s_cyc_o and gnt_o zero without a clock edge; after release master 0 is granted first.
REQ-035 Single requester master 3 issuing back-to-back cycles -> regranted each time after one IDLE cycle.
